// File: rtl/enc_dec_scheduler.sv
// -----------------------------------------------------------------------------
// enc_dec_scheduler
//
// Shares one encoder/decoder core between NUM_REQ requesters. A round-robin
// arbiter picks one request at a time in IDLE, the operation is launched on
// the core with a single start pulse, the scheduler waits for completion (or
// gives up after TIMEOUT_CYCLES), and the result is returned on the owning
// requester's response channel. Saturating usage/error counters are kept.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_type_of_work         2 bits per requester: 1=encode, 2=decode
//   req_data                 DATA_WIDTH bits per requester
//   resp_valid/resp_ready    per-requester response handshake (valid one-hot)
//   resp_data                shared response data
//   resp_num_of_errors       core error count (0 for encode / errors)
//   resp_err                 illegal type_of_work or timeout
//   core_start               one-cycle launch pulse to the core
//   core_type_of_work        operation sent to the core
//   core_data_in             operand sent to the core
//   core_operation_done      core completion strobe
//   core_data_out            core result
//   core_num_of_errors       core error count
//   cnt_encode/cnt_decode    accepted encode/decode operations (saturating)
//   cnt_uncorrectable        completed decodes reporting 2 errors (saturating)
// -----------------------------------------------------------------------------
module enc_dec_scheduler #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [2*NUM_REQ-1:0]          req_type_of_work,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]            resp_valid,
   input  logic [NUM_REQ-1:0]            resp_ready,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic [1:0]                    resp_num_of_errors,
   output logic                          resp_err,
   output logic                          core_start,
   output logic [1:0]                    core_type_of_work,
   output logic [DATA_WIDTH-1:0]         core_data_in,
   input  logic                          core_operation_done,
   input  logic [DATA_WIDTH-1:0]         core_data_out,
   input  logic [1:0]                    core_num_of_errors,
   output logic [15:0]                   cnt_encode,
   output logic [15:0]                   cnt_decode,
   output logic [15:0]                   cnt_uncorrectable
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [1:0]              op_type_q, op_type_d;
   logic [DATA_WIDTH-1:0]   op_data_q, op_data_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rnerr_q, rnerr_d;
   logic                    rerr_q, rerr_d;
   logic [15:0]             cnt_enc_q, cnt_enc_d;
   logic [15:0]             cnt_dec_q, cnt_dec_d;
   logic [15:0]             cnt_unc_q, cnt_unc_d;

   // Per-requester views of the packed request buses.
   logic [1:0]              req_type_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]   req_data_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_type_arr[gi] = req_type_of_work[2*gi +: 2];
         assign req_data_arr[gi] = req_data[DATA_WIDTH*gi +: DATA_WIDTH];
      end
   endgenerate

   // Round-robin search: first valid requester starting at ptr_q, wrapping.
   logic                    gnt_found;
   logic [IDX_W-1:0]        gnt_idx;
   logic [IDX_W-1:0]        cand_idx;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_idx  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand_idx = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
         if (!gnt_found && req_valid[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      op_type_d = op_type_q;
      op_data_d = op_data_q;
      tmo_d     = tmo_q;
      rdata_d   = rdata_q;
      rnerr_d   = rnerr_q;
      rerr_d    = rerr_q;
      cnt_enc_d = cnt_enc_q;
      cnt_dec_d = cnt_dec_q;
      cnt_unc_d = cnt_unc_q;

      unique case (state_q)
         ST_IDLE: begin
            // req_ready follows gnt_found, so a found grant is a handshake.
            if (gnt_found) begin
               idx_d     = gnt_idx;
               op_type_d = req_type_arr[gnt_idx];
               op_data_d = req_data_arr[gnt_idx];
               ptr_d     = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               case (req_type_arr[gnt_idx])
                  2'd1: begin
                     if (cnt_enc_q != 16'hFFFF) cnt_enc_d = cnt_enc_q + 16'd1;
                     state_d = ST_ISSUE;
                  end
                  2'd2: begin
                     if (cnt_dec_q != 16'hFFFF) cnt_dec_d = cnt_dec_q + 16'd1;
                     state_d = ST_ISSUE;
                  end
                  default: begin
                     // Illegal operation: answer with an error, core untouched.
                     rdata_d = '0;
                     rnerr_d = 2'd0;
                     rerr_d  = 1'b1;
                     state_d = ST_RESP;
                  end
               endcase
            end
         end

         ST_ISSUE: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (core_operation_done) begin
               rdata_d = core_data_out;
               rnerr_d = (op_type_q == 2'd2) ? core_num_of_errors : 2'd0;
               rerr_d  = 1'b0;
               if ((op_type_q == 2'd2) && (core_num_of_errors == 2'd2) &&
                   (cnt_unc_q != 16'hFFFF)) begin
                  cnt_unc_d = cnt_unc_q + 16'd1;
               end
               state_d = ST_RESP;
            end else if (tmo_q == TMO_LAST) begin
               rdata_d = '0;
               rnerr_d = 2'd0;
               rerr_d  = 1'b1;
               state_d = ST_RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_RESP: begin
            if (resp_ready[idx_q]) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         op_type_q <= 2'd0;
         op_data_q <= '0;
         tmo_q     <= '0;
         rdata_q   <= '0;
         rnerr_q   <= 2'd0;
         rerr_q    <= 1'b0;
         cnt_enc_q <= 16'd0;
         cnt_dec_q <= 16'd0;
         cnt_unc_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         op_type_q <= op_type_d;
         op_data_q <= op_data_d;
         tmo_q     <= tmo_d;
         rdata_q   <= rdata_d;
         rnerr_q   <= rnerr_d;
         rerr_q    <= rerr_d;
         cnt_enc_q <= cnt_enc_d;
         cnt_dec_q <= cnt_dec_d;
         cnt_unc_q <= cnt_unc_d;
      end
   end

   // Outputs
   logic core_active;
   logic in_resp;

   assign core_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign in_resp     = (state_q == ST_RESP);

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_hs
         assign req_ready[gi]  = (state_q == ST_IDLE) && gnt_found &&
                                 (gnt_idx == IDX_W'(gi));
         assign resp_valid[gi] = in_resp && (idx_q == IDX_W'(gi));
      end
   endgenerate

   assign core_start         = (state_q == ST_ISSUE);
   assign core_type_of_work  = core_active ? op_type_q : 2'd0;
   assign core_data_in       = core_active ? op_data_q : '0;
   assign resp_data          = in_resp ? rdata_q : '0;
   assign resp_num_of_errors = in_resp ? rnerr_q : 2'd0;
   assign resp_err           = in_resp ? rerr_q : 1'b0;
   assign cnt_encode         = cnt_enc_q;
   assign cnt_decode         = cnt_dec_q;
   assign cnt_uncorrectable  = cnt_unc_q;

endmodule

// File: tb/tb_enc_dec_scheduler.sv
// -----------------------------------------------------------------------------
// tb_enc_dec_scheduler
//
// Self-checking bench for enc_dec_scheduler. The bench plays both the
// requesters and the core; a reference model tracks the round-robin pointer,
// expected result of each operation and the saturating counters.
// -----------------------------------------------------------------------------
module tb_enc_dec_scheduler;

   localparam int DW  = 32;
   localparam int NR  = 2;
   localparam int TMO = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [2*NR-1:0] req_type_of_work;
   logic [DW*NR-1:0] req_data;
   logic [NR-1:0]   resp_valid;
   logic [NR-1:0]   resp_ready;
   logic [DW-1:0]   resp_data;
   logic [1:0]      resp_num_of_errors;
   logic            resp_err;
   logic            core_start;
   logic [1:0]      core_type_of_work;
   logic [DW-1:0]   core_data_in;
   logic            core_operation_done;
   logic [DW-1:0]   core_data_out;
   logic [1:0]      core_num_of_errors;
   logic [15:0]     cnt_encode;
   logic [15:0]     cnt_decode;
   logic [15:0]     cnt_uncorrectable;

   int n_checks = 0;
   int n_fail   = 0;
   int txn      = 0;

   // Reference model state
   int exp_ptr;
   int exp_enc;
   int exp_dec;
   int exp_unc;

   always #5 clk = ~clk;

   enc_dec_scheduler #(
      .DATA_WIDTH    (DW),
      .NUM_REQ       (NR),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_type_of_work   (req_type_of_work),
      .req_data           (req_data),
      .resp_valid         (resp_valid),
      .resp_ready         (resp_ready),
      .resp_data          (resp_data),
      .resp_num_of_errors (resp_num_of_errors),
      .resp_err           (resp_err),
      .core_start         (core_start),
      .core_type_of_work  (core_type_of_work),
      .core_data_in       (core_data_in),
      .core_operation_done(core_operation_done),
      .core_data_out      (core_data_out),
      .core_num_of_errors (core_num_of_errors),
      .cnt_encode         (cnt_encode),
      .cnt_decode         (cnt_decode),
      .cnt_uncorrectable  (cnt_uncorrectable)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // First valid requester at or after ptr, modulo NR.
   function automatic int model_grant(input logic [NR-1:0] mask, input int ptr);
      int c;
      for (int off = 0; off < NR; off++) begin
         c = (ptr + off) % NR;
         if (((mask >> c) & 1) != 0) return c;
      end
      return 0;
   endfunction

   task automatic model_reset();
      exp_ptr = 0;
      exp_enc = 0;
      exp_dec = 0;
      exp_unc = 0;
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_req_ready"},  req_ready, 0);
      check_val({tag, "_resp_valid"}, resp_valid, 0);
      check_val({tag, "_resp_data"},  resp_data, 0);
      check_val({tag, "_resp_nerr"},  resp_num_of_errors, 0);
      check_val({tag, "_resp_err"},   resp_err, 0);
      check_val({tag, "_core_start"}, core_start, 0);
      check_val({tag, "_core_type"},  core_type_of_work, 0);
      check_val({tag, "_core_data"},  core_data_in, 0);
      check_val({tag, "_cnt_enc"},    cnt_encode, 0);
      check_val({tag, "_cnt_dec"},    cnt_decode, 0);
      check_val({tag, "_cnt_unc"},    cnt_uncorrectable, 0);
   endtask

   // One complete operation. delay < 0 means the core never finishes;
   // otherwise done is raised in WAIT cycle 'delay'. rdly = response stall.
   task automatic do_op(input logic [1:0] mask, input logic [1:0] t0, input logic [1:0] t1,
                        input logic [31:0] d0, input logic [31:0] d1, input int delay,
                        input logic [31:0] cout, input logic [1:0] cnerr, input int rdly);
      int          g;
      int          i;
      int          exp_lat;
      logic [1:0]  gm;
      logic [1:0]  op_t;
      logic [31:0] op_d;
      bit          legal;
      bit          tmo;
      logic [31:0] e_data;
      logic [1:0]  e_nerr;
      logic        e_err;

      @(negedge clk);
      resp_ready          = '0;
      core_operation_done = 1'b0;
      req_valid           = mask;
      req_type_of_work    = {t1, t0};
      req_data            = {d1, d0};
      #1;
      g    = model_grant(mask, exp_ptr);
      gm   = 2'(1 << g);
      op_t = (g == 1) ? t1 : t0;
      op_d = (g == 1) ? d1 : d0;
      check_val("idle_resp_valid", resp_valid, 0);
      check_val("grant", req_ready, gm);
      legal   = (op_t == 2'd1) || (op_t == 2'd2);
      exp_ptr = (g + 1) % NR;
      if (op_t == 2'd1) exp_enc = sat16(exp_enc + 1);
      if (op_t == 2'd2) exp_dec = sat16(exp_dec + 1);

      // Scramble the request operands: the DUT must use its latched copies.
      @(negedge clk);
      req_data = {$urandom, $urandom};
      #1;
      check_val("busy_ready", req_ready, 0);
      check_val("core_start", core_start, legal);
      tmo     = 1'b0;
      exp_lat = 0;
      i       = 0;
      if (legal) begin
         check_val("core_type", core_type_of_work, op_t);
         check_val("core_data", core_data_in, op_d);
         tmo     = (delay < 0);
         exp_lat = tmo ? TMO : delay + 1;
         while (i < TMO + 8) begin
            @(negedge clk);
            core_operation_done = (i == delay);
            core_data_out       = (i == delay) ? cout : $urandom;
            core_num_of_errors  = (i == delay) ? cnerr : 2'($urandom);
            #1;
            if (resp_valid != 0) break;
            check_val("wait_hold", {core_start, core_type_of_work, core_data_in},
                      {1'b0, op_t, op_d});
            i++;
         end
         core_operation_done = 1'b0;
         check_val("latency", i, exp_lat);
         if (!tmo && op_t == 2'd2 && cnerr == 2'd2) exp_unc = sat16(exp_unc + 1);
      end

      e_err  = !legal || tmo;
      e_data = e_err ? 32'd0 : cout;
      e_nerr = (!e_err && op_t == 2'd2) ? cnerr : 2'd0;
      check_val("resp_valid", resp_valid, gm);
      check_val("resp_data", resp_data, e_data);
      check_val("resp_nerr", resp_num_of_errors, e_nerr);
      check_val("resp_err", resp_err, e_err);
      check_val("cnt_encode", cnt_encode, exp_enc);
      check_val("cnt_decode", cnt_decode, exp_dec);
      check_val("cnt_uncorr", cnt_uncorrectable, exp_unc);

      // Non-owner ready must not release the response.
      for (int k = 0; k < rdly; k++) begin
         @(negedge clk);
         resp_ready = ~gm;
         #1;
         check_val("resp_hold", {resp_valid, resp_err, resp_num_of_errors, resp_data},
                   {gm, e_err, e_nerr, e_data});
      end
      @(negedge clk);
      resp_ready = gm;
      txn++;
      $display("txn %0d: mask=%b grant=%0d type=%0d data=0x%08h lat=%0d err=%0b nerr=%0d",
               txn, mask, g, op_t, op_d, i, e_err, e_nerr);
   endtask

   // Bounded run time in case the DUT wedges the bench.
   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] m;
      logic [1:0] ta;
      logic [1:0] tb;
      int         r;
      int         dly;

      rst                 = 1'b1;
      req_valid           = '0;
      req_type_of_work    = '0;
      req_data            = '0;
      resp_ready          = '0;
      core_operation_done = 1'b0;
      core_data_out       = '0;
      core_num_of_errors  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_zero("in_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("after_reset");

      // Single encode from req0; core reports errors which must be masked.
      do_op(2'b01, 2'd1, 2'd0, 32'h0000_00A5, 32'h0, 2, 32'h1234_5678, 2'd1, 0);

      // Both requesters continuously valid: grants alternate.
      for (int k = 0; k < 4; k++)
         do_op(2'b11, 2'd1, 2'd2, $urandom, $urandom, k, $urandom, 2'(k), 0);

      // Decodes from req1 with 0, 1, 2 errors.
      for (int k = 0; k < 3; k++)
         do_op(2'b10, 2'd0, 2'd2, 32'h0, $urandom, 1, $urandom, 2'(k), 1);

      // Illegal types, then a normal request.
      do_op(2'b01, 2'd3, 2'd0, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, 2'd0, 1);
      do_op(2'b10, 2'd0, 2'd0, 32'h0, 32'hCAFE_F00D, 0, 32'h0, 2'd0, 0);
      do_op(2'b01, 2'd1, 2'd0, 32'h5555_AAAA, 32'h0, 0, 32'h0F0F_0F0F, 2'd0, 0);

      // Timeout, then a late done in IDLE that must be ignored.
      do_op(2'b10, 2'd0, 2'd2, 32'h0, 32'h1111_2222, -1, 32'h0, 2'd0, 0);
      @(negedge clk);
      resp_ready          = '0;
      req_valid           = '0;
      core_operation_done = 1'b1;
      core_data_out       = 32'h7777_7777;
      #1;
      check_val("late_idle_resp", resp_valid, 0);
      @(negedge clk);
      core_operation_done = 1'b0;
      #1;
      check_val("late_done_ignored", {resp_valid, core_start}, 0);

      // Done and timeout in the same cycle: done wins.
      do_op(2'b01, 2'd2, 2'd0, 32'h3333_4444, 32'h0, TMO - 1, 32'h9999_8888, 2'd2, 0);

      // Reset while in WAIT, with a done arriving after reset.
      @(negedge clk);
      resp_ready       = '0;
      req_valid        = 2'b01;
      req_type_of_work = {2'd1, 2'd1};
      req_data         = {32'h0, 32'h1357_9BDF};
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check_val("pre_rst_wait_type", core_type_of_work, 2'd1);
      rst = 1'b1;
      @(negedge clk);
      rst                 = 1'b0;
      core_operation_done = 1'b1;
      core_data_out       = 32'h2468_ACE0;
      model_reset();
      #1;
      check_zero("rst_wait");
      @(negedge clk);
      core_operation_done = 1'b0;
      #1;
      check_val("rst_late_done", {resp_valid, core_start}, 0);
      do_op(2'b11, 2'd1, 2'd2, 32'hAAAA_0000, 32'hBBBB_0000, 0, 32'hC0DE_0001, 2'd0, 0);

      // Randomized operations.
      for (int k = 0; k < 30; k++) begin
         m  = 2'($urandom_range(1, 3));
         r  = $urandom_range(0, 9);
         ta = (r < 8) ? 2'((r % 2) + 1) : ((r == 8) ? 2'd0 : 2'd3);
         r  = $urandom_range(0, 9);
         tb = (r < 8) ? 2'((r % 2) + 1) : ((r == 8) ? 2'd0 : 2'd3);
         r  = $urandom_range(0, 19);
         dly = (r < 16) ? (r % 8) : ((r == 16) ? TMO - 1 : ((r == 17) ? TMO - 2 : -1));
         do_op(m, ta, tb, $urandom, $urandom, dly, $urandom, 2'($urandom),
               $urandom_range(0, 2));
      end

      @(negedge clk);
      resp_ready = '0;
      req_valid  = '0;
      #1;
      check_val("final_idle", {resp_valid, core_start}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
